// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: ctrl/data payload, valid/ready
// handshake, optional two-entry skid, flush/hold, profiling counters.
module pipe_stage_reg #(
  parameter int CTRL_W    = 16,
  parameter int DATA_W    = 128,
  parameter int SKID      = 1,
  parameter int CLEAR_ALL = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_v;
  logic [CTRL_W-1:0] main_c;
  logic [DATA_W-1:0] main_d;
  logic              skid_v;
  logic              accept;
  logic              pop;

  assign pop       = main_v & out_ready & ~hold;
  assign accept    = in_valid & in_ready;
  assign out_valid = main_v & ~hold;
  assign out_ctrl  = out_valid ? main_c : '0;
  assign out_data  = main_d;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] skid_c;
      logic [DATA_W-1:0] skid_d;

      // Registered ready: the skid slot absorbs the beat in flight.
      assign in_ready = ~skid_v & ~rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          main_v <= 1'b0;
          main_c <= '0;
          main_d <= '0;
          skid_v <= 1'b0;
          skid_c <= '0;
          skid_d <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
          main_c <= '0;
          skid_v <= 1'b0;
          skid_c <= '0;
          if (CLEAR_ALL != 0) begin
            main_d <= '0;
            skid_d <= '0;
          end
        end else if (pop) begin
          if (skid_v) begin
            main_c <= skid_c;
            main_d <= skid_d;
            skid_v <= 1'b0;
          end else if (accept) begin
            main_c <= in_ctrl;
            main_d <= in_data;
          end else begin
            main_v <= 1'b0;
          end
        end else if (accept) begin
          if (!main_v) begin
            main_v <= 1'b1;
            main_c <= in_ctrl;
            main_d <= in_data;
          end else begin
            skid_v <= 1'b1;
            skid_c <= in_ctrl;
            skid_d <= in_data;
          end
        end
      end
    end else begin : g_single
      assign skid_v   = 1'b0;
      assign in_ready = (~main_v | pop) & ~rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          main_v <= 1'b0;
          main_c <= '0;
          main_d <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
          main_c <= '0;
          if (CLEAR_ALL != 0) begin
            main_d <= '0;
          end
        end else if (accept) begin
          main_v <= 1'b1;
          main_c <= in_ctrl;
          main_d <= in_data;
        end else if (pop) begin
          main_v <= 1'b0;
        end
      end
    end
  endgenerate

  // Saturating profile counters; a flushed head is not a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!main_v && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
      if (main_v && !pop && !flush && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: default skid stage, a CLEAR_ALL=0 / CNT_W=4 skid
// stage and a SKID=0 stage, all driven by the same stimulus.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         hold;
  logic         in_valid;
  logic [15:0]  in_ctrl;
  logic [127:0] in_data;
  logic         out_ready;

  logic         a_ird, a_ov, b_ird, b_ov, c_ird, c_ov;
  logic [15:0]  a_oc, b_oc, c_oc;
  logic [127:0] a_od, b_od, c_od;
  logic [1:0]   a_occ, b_occ, c_occ;
  logic [15:0]  a_stall, a_bub, c_stall, c_bub;
  logic [3:0]   b_stall, b_bub;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_a (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(a_ird),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_ctrl(a_oc), .out_data(a_od), .occupancy(a_occ),
    .stall_cnt(a_stall), .bubble_cnt(a_bub)
  );

  pipe_stage_reg #(.CLEAR_ALL(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(b_ird),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready),
    .out_ctrl(b_oc), .out_data(b_od), .occupancy(b_occ),
    .stall_cnt(b_stall), .bubble_cnt(b_bub)
  );

  pipe_stage_reg #(.SKID(0)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(c_ird),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(c_ov), .out_ready(out_ready),
    .out_ctrl(c_oc), .out_data(c_od), .occupancy(c_occ),
    .stall_cnt(c_stall), .bubble_cnt(c_bub)
  );

  typedef struct {
    logic         iv;
    logic [15:0]  ic;
    logic [127:0] id;
    logic         ordy;
    logic         hld;
    logic         fl;
    logic         ov;
    logic [15:0]  oc;
    logic [127:0] od;
    logic [1:0]   occ;
    logic         ird;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [127:0] pat(input logic [31:0] w);
    return {4{w}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [15:0] ic,
                       input logic [127:0] id, input logic ordy,
                       input logic hld, input logic fl);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    hold      = hld;
    flush     = fl;
  endtask

  logic [15:0] s_save;

  initial begin
    // iv ic id ordy hold flush | ov oc od occ ird
    tbl[0]  = '{1, 16'h0013, pat(32'hA5A5A5A5), 1, 0, 0,
                1, 16'h0013, pat(32'hA5A5A5A5), 2'd1, 1};
    tbl[1]  = '{1, 16'h0014, pat(32'hD1D1D1D1), 1, 0, 0,
                1, 16'h0014, pat(32'hD1D1D1D1), 2'd1, 1};
    tbl[2]  = '{1, 16'h0015, pat(32'hD2D2D2D2), 1, 0, 0,
                1, 16'h0015, pat(32'hD2D2D2D2), 2'd1, 1};
    tbl[3]  = '{0, 16'h0000, '0, 1, 0, 0,
                0, 16'h0000, pat(32'hD2D2D2D2), 2'd0, 1};
    tbl[4]  = '{1, 16'h0021, pat(32'hE1E1E1E1), 0, 0, 0,
                1, 16'h0021, pat(32'hE1E1E1E1), 2'd1, 1};
    tbl[5]  = '{1, 16'h0022, pat(32'hE2E2E2E2), 0, 0, 0,
                1, 16'h0021, pat(32'hE1E1E1E1), 2'd2, 0};
    tbl[6]  = '{1, 16'h0023, pat(32'hE3E3E3E3), 0, 0, 0,
                1, 16'h0021, pat(32'hE1E1E1E1), 2'd2, 0};
    tbl[7]  = '{1, 16'h0023, pat(32'hE3E3E3E3), 1, 0, 0,
                1, 16'h0022, pat(32'hE2E2E2E2), 2'd1, 1};
    tbl[8]  = '{1, 16'h0023, pat(32'hE3E3E3E3), 1, 0, 0,
                1, 16'h0023, pat(32'hE3E3E3E3), 2'd1, 1};
    tbl[9]  = '{0, 16'h0000, '0, 1, 0, 0,
                0, 16'h0000, pat(32'hE3E3E3E3), 2'd0, 1};
    tbl[10] = '{1, 16'h0031, pat(32'hF1F1F1F1), 0, 0, 0,
                1, 16'h0031, pat(32'hF1F1F1F1), 2'd1, 1};
    tbl[11] = '{1, 16'h0032, pat(32'hF2F2F2F2), 0, 0, 0,
                1, 16'h0031, pat(32'hF1F1F1F1), 2'd2, 0};
    tbl[12] = '{1, 16'h0033, pat(32'hF3F3F3F3), 0, 0, 1,
                0, 16'h0000, '0, 2'd0, 1};
    tbl[13] = '{1, 16'h0041, pat(32'h61616161), 1, 0, 0,
                1, 16'h0041, pat(32'h61616161), 2'd1, 1};
    for (int k = 14; k <= 18; k++) begin
      tbl[k] = '{0, 16'h0000, '0, 1, 1, 0,
                 0, 16'h0000, pat(32'h61616161), 2'd1, 1};
    end
    tbl[19] = '{0, 16'h0000, '0, 0, 0, 0,
                1, 16'h0041, pat(32'h61616161), 2'd1, 1};
    tbl[20] = '{0, 16'h0000, '0, 1, 0, 0,
                0, 16'h0000, pat(32'h61616161), 2'd0, 1};

    // Reset state
    rst = 1'b1;
    drive(0, '0, '0, 0, 0, 0);
    step();
    step();
    chk("rst_a_in_ready", a_ird, 0);
    chk("rst_c_in_ready", c_ird, 0);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out_ctrl", a_oc, 0);
    chk("rst_out_data", a_od, 0);
    chk("rst_occupancy", a_occ, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_bubble", a_bub, 0);

    // Idle bubbles: 20 on the wide counter, saturate at 15 on CNT_W=4
    rst = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("idle_bubble_a", a_bub, 20);
    chk("idle_bubble_b_sat", b_bub, 15);
    chk("idle_in_ready", a_ird, 1);
    rst = 1'b1;
    step();
    chk("rst_pulse_bubble_a", a_bub, 0);
    chk("rst_pulse_bubble_b", b_bub, 0);
    rst = 1'b0;

    s_save = '0;
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy,
            tbl[i].hld, tbl[i].fl);
      step();
      chk($sformatf("v%0d_out_valid", i), a_ov, tbl[i].ov);
      chk($sformatf("v%0d_out_ctrl", i), a_oc, tbl[i].oc);
      chk($sformatf("v%0d_out_data", i), a_od, tbl[i].od);
      chk($sformatf("v%0d_occupancy", i), a_occ, tbl[i].occ);
      chk($sformatf("v%0d_in_ready", i), a_ird, tbl[i].ird);
      if (i == 11 || i == 13) s_save = a_stall;
      if (i == 12) begin
        chk("flush_no_stall", a_stall, s_save);
        chk("flush_keep_data_b", b_od, pat(32'hF1F1F1F1));
        chk("flush_ctrl_b", b_oc, 0);
        chk("flush_occ_b", b_occ, 0);
      end
      if (i == 18) chk("hold_stall_plus5", a_stall, s_save + 16'd5);
    end

    // SKID=0: combinational ready, replace-on-pop
    drive(0, '0, '0, 0, 0, 1);
    step();
    chk("s0_flush_occ", c_occ, 0);
    drive(1, 16'h0051, pat(32'h51515151), 0, 0, 0);
    step();
    chk("s0_load_valid", c_ov, 1);
    chk("s0_load_ctrl", c_oc, 16'h0051);
    drive(1, 16'h0052, pat(32'h52525252), 0, 0, 0);
    #1;
    chk("s0_full_not_ready", c_ird, 0);
    out_ready = 1'b1;
    #1;
    chk("s0_comb_ready", c_ird, 1);
    step();
    chk("s0_replace_ctrl", c_oc, 16'h0052);
    chk("s0_replace_data", c_od, pat(32'h52525252));
    chk("s0_replace_occ", c_occ, 1);
    drive(1, 16'h0053, pat(32'h53535353), 1, 1, 0);
    #1;
    chk("s0_hold_not_ready", c_ird, 0);
    chk("s0_hold_no_valid", c_ov, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
